// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// active-low hex font, segment bit positions and the all-off pattern.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry k is the active-low glyph for nibble k, dp bit off.
  localparam logic [15:0][7:0] FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low segment pattern; blanking kills a..g
// but the decimal point still follows its own enable.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : FONT[i_nib];
    o_seg[SEG_DP] = ~i_dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex display driver with PWM brightness,
// leading-zero suppression and per-digit blink.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV_W    = 15,
  parameter int BRIGHT_W = 4,
  parameter int BLINK_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [7:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_sel
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [BLINK_W-1:0]    r_frame;
  logic [4*N_DIGITS-1:0] r_data;
  logic [N_DIGITS-1:0]   r_dp;
  logic [7:0]            r_seg;
  logic [N_DIGITS-1:0]   r_sel;

  logic                  w_tick;
  logic [BRIGHT_W-1:0]   w_phase;
  logic                  w_en;
  logic [3:0]            w_nib;
  logic                  w_run;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_blank;
  logic [7:0]            w_seg;
  logic [N_DIGITS-1:0]   w_sel;

  assign w_tick  = &r_presc;
  assign w_phase = r_presc[DIV_W-1 -: BRIGHT_W];
  assign w_en    = (&brightness) | (w_phase < brightness);
  assign w_nib   = r_data[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_data  <= '0;
      r_dp    <= '0;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
      if (w_tick) begin
        if (r_idx == LAST) begin
          r_idx   <= '0;
          r_frame <= r_frame + BLINK_W'(1);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (we) begin
        r_data <= i_data;
        r_dp   <= i_dp;
      end
    end
  end

  // A digit is LZ-blanked while every nibble from the top down to it is zero.
  always_comb begin
    w_run = blank_lz;
    w_lz  = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_run   = w_run & (r_data[4*k +: 4] == 4'h0);
      w_lz[k] = w_run;
    end
  end

  assign w_blank = w_lz[r_idx]
                 | (blink_mask[r_idx] & r_frame[BLINK_W-1]);

  seg7_hex_decode u_dec (
    .i_nib   (w_nib),
    .i_dp    (r_dp[r_idx]),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_comb begin
    w_sel        = '1;
    w_sel[r_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !w_en) begin
      r_sel <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_sel <= w_sel;
      r_seg <= w_seg;
    end
  end

  assign o_seg = r_seg;
  assign o_sel = r_sel;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a cycle-count reference model predicts each
// registered output; a monitor pops and compares every cycle.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] i_data;
  logic [7:0]  i_dp;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [7:0]  blink_mask;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q[$];
  int          m_c;
  logic [31:0] m_d;
  logic [7:0]  m_dp;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS (8),
    .DIV_W    (4),
    .BRIGHT_W (4),
    .BLINK_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .i_data     (i_data),
    .i_dp       (i_dp),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .o_seg      (o_seg),
    .o_sel      (o_sel)
  );

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 8'hC0; 4'h1: font = 8'hF9;
      4'h2: font = 8'hA4; 4'h3: font = 8'hB0;
      4'h4: font = 8'h99; 4'h5: font = 8'h92;
      4'h6: font = 8'h82; 4'h7: font = 8'hF8;
      4'h8: font = 8'h80; 4'h9: font = 8'h90;
      4'hA: font = 8'h88; 4'hB: font = 8'h83;
      4'hC: font = 8'hC6; 4'hD: font = 8'hA1;
      4'hE: font = 8'h86; default: font = 8'h8E;
    endcase
  endfunction

  // Expected {sel, seg} for the state reached c cycles after reset.
  function automatic logic [15:0] f_exp(
    input int c, input logic [31:0] d, input logic [7:0] dp,
    input logic lz, input logic [3:0] br, input logic [7:0] bm);
    int presc, slot, idx, frame;
    logic [7:0] seg, sel, g;
    logic [31:0] upper;
    bit blank;
    presc = c % 16;
    slot  = c / 16;
    idx   = slot % 8;
    frame = (slot / 8) % 4;
    if (!(br == 4'hF || presc < int'(br))) return 16'hFFFF;
    upper = d >> (4 * idx);
    blank = (lz && idx != 0 && upper == 0) || (bm[idx] && frame >= 2);
    g = font(upper[3:0]);
    seg[6:0] = blank ? 7'h7F : g[6:0];
    seg[7] = ~dp[idx];
    sel = ~(8'(1) << idx);
    return {sel, seg};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.push_back(16'hFFFF);
      m_c  <= 0;
      m_d  <= '0;
      m_dp <= '0;
    end else begin
      q.push_back(f_exp(m_c, m_d, m_dp, blank_lz, brightness, blink_mask));
      m_c <= m_c + 1;
      if (we) begin
        m_d  <= i_data;
        m_dp <= i_dp;
      end
    end
  end

  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    n_chk++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = q.pop_front();
      if ({o_sel, o_seg} !== e) begin
        n_err++;
        $display("FAIL scan t=%0t c=%0d got sel=%h seg=%h want sel=%h seg=%h",
                 $time, m_c, o_sel, o_seg, e[15:8], e[7:0]);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] p);
    i_data = d;
    i_dp   = p;
    we     = 1'b1;
    @(negedge clk);
    we     = 1'b0;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 8; k++)
      if ($urandom % 2 == 1) d[4*k +: 4] = 4'($urandom % 16);
    return d;
  endfunction

  initial begin
    int guard;
    rst        = 1'b1;
    we         = 1'b0;
    i_data     = '0;
    i_dp       = '0;
    blank_lz   = 1'b0;
    brightness = 4'hF;
    blink_mask = '0;
    run(3);
    rst = 1'b0;

    load(32'h1234ABCD, 8'h00);
    run(140);

    blank_lz = 1'b1;
    load(32'h00000050, 8'h20);
    run(130);
    load(32'h0, 8'h00);
    run(130);

    blank_lz = 1'b0;
    load($urandom, 8'($urandom));
    brightness = 4'd4;
    run(130);
    brightness = 4'd0;
    run(130);
    brightness = 4'hF;

    blink_mask = 8'h01;
    run(520);
    blink_mask = 8'h00;

    guard = 0;
    while ((((m_c / 16) % 8) != 3 || (m_c % 16) != 7) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL digit3_wait got guard=%0d want <200", guard);
    end
    load(32'h9ABCDEF0, 8'h08);
    run(40);

    run(37);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(150);

    for (int i = 0; i < 3000; i++) begin
      we  = ($urandom % 8 == 0);
      rst = ($urandom % 500 == 0);
      if (we) begin
        i_data = rnd_data();
        i_dp   = 8'($urandom);
      end
      if ($urandom % 50 == 0) blank_lz = ~blank_lz;
      if ($urandom % 40 == 0) brightness = 4'($urandom);
      if ($urandom % 60 == 0) blink_mask = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    we  = 1'b0;
    run(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL take parameter N_DIGITS, default 8: number of multiplexed hex digits, 1..16.
REQ-002 SHALL take parameter DIV_W, default 15: each digit slot lasts 2**DIV_W clk cycles.
REQ-003 SHALL take parameter BRIGHT_W, default 4: width of the brightness control, with BRIGHT_W <= DIV_W.
REQ-004 SHALL take parameter BLINK_W, default 5: frame-counter width; blink period is 2**BLINK_W frames.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 we  in  1  latch i_data/i_dp into the display register.
REQ-008 i_data  in  4*N_DIGITS  hex nibbles; nibble k shows on digit k, where digit 0 is the least significant.
REQ-009 i_dp  in  N_DIGITS  per-digit decimal point, 1 = lit.
REQ-010 blank_lz  in  1  leading-zero suppression enable.
REQ-011 brightness  in  BRIGHT_W  anode duty control.
REQ-012 blink_mask  in  N_DIGITS  1 = digit blinks.
REQ-013 o_seg  out  8  active-low segment bus {dp,g,f,e,d,c,b,a}.
REQ-014 o_sel  out  N_DIGITS  active-low anode select, at most one bit low.

Function
REQ-015 The display register SHALL load on the rising edge where we=1; scan state SHALL be unaffected by the load.
REQ-016 The prescaler SHALL count 0..2**DIV_W-1 and wrap to 0; the wrap is the slot tick.
REQ-017 The digit index SHALL advance on each tick, wrapping from N_DIGITS-1 to 0; each wrap is a frame end.
REQ-018 The frame counter (BLINK_W bits) SHALL increment at each frame end and wrap freely.
REQ-019 Slot phase SHALL be prescaler[DIV_W-1 -: BRIGHT_W].
REQ-020 The anode SHALL be enabled iff brightness is all-ones, or phase < brightness; brightness=0 keeps all anodes off.
REQ-021 A digit SHALL be blanked when its blink_mask bit is 1 and the frame counter MSB is 1.
REQ-022 With blank_lz=1, each contiguous run of zero nibbles from digit N_DIGITS-1 downward SHALL be blanked; digit 0 is never LZ-blanked.
REQ-023 A blanked digit SHALL drive all segments a..g off, while still driving dp from i_dp.
REQ-024 Non-blanked digits SHALL use the standard hex font (0-9, A, b, C, d, E, F).
REQ-025 o_seg and o_sel SHALL be registered, with one cycle of latency from index/data/control to output.
REQ-026 When the anode is disabled, o_sel SHALL be all-ones and o_seg SHALL be 8'hFF.
REQ-027 Inputs blank_lz, brightness and blink_mask SHALL be used live, not latched.

Reset
REQ-028 While rst=1, the module SHALL clear the prescaler, index, frame counter and display register (data and dp) to 0.
REQ-029 While rst=1, o_sel SHALL be all-ones and o_seg SHALL be 8'hFF.
REQ-030 Reset asserted mid-slot or mid-frame SHALL take effect at the next edge.
REQ-031 After reset, the first output cycle following release SHALL show digit 0.

Structure
REQ-032 Package seg7_pkg SHALL hold the 16-entry active-low font constant, the segment bit-order localparams, and the blank pattern 8'hFF.
REQ-033 Sub-module seg7_hex_decode SHALL be the single natural sub-module: combinational nibble+dp+blank -> 8-bit segments.
REQ-034 The scan counters, LZ logic and PWM SHALL stay in the top module.

Verification (N_DIGITS=8, DIV_W=4, BRIGHT_W=4, BLINK_W=2)
REQ-035 Reset: hold rst 3 cycles -> o_sel=8'hFF, o_seg=8'hFF; with brightness=4'hF, the first cycle after release gives o_sel=8'hFE.
REQ-036 Decode: we with i_data=32'h1234ABCD, i_dp=0, brightness=4'hF -> digit0 o_seg=8'hA1 ('d'), digit7 o_seg=8'hF9 ('1'); each o_sel value is held 16 cycles.
REQ-037 Leading-zero suppression:
- i_data=32'h00000050, blank_lz=1 -> digits 7..2 o_seg=8'hFF, digit1 8'h92, digit0 8'hC0.
- i_data=0 -> only digit0 shows 8'hC0.
- i_dp[5]=1 -> digit5 o_seg=8'h7F.
REQ-038 Brightness:
- brightness=4 -> o_sel is low for 4 of 16 cycles per slot.
- brightness=0 -> o_sel stays 8'hFF across a full frame.
REQ-039 Blink: blink_mask=8'h01 -> digit0 is shown in frames 0-1 and blanked (8'hFF) in frames 2-3 of every 4; other digits are unaffected.
REQ-040 Boundaries:
- we during digit 3's slot -> the new value appears on the next output cycle, with the index unchanged.
- rst pulsed mid-frame -> o_sel=8'hFF next cycle, and the scan restarts at digit 0.
